instruction_fetch: RTL



---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_out_reg.sv | 43 ++++
 rtl/instruction_fetch.sv | 95 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: bus widths, halt opcode and fetch FSM states.
package cpu_pkg;

  localparam int unsigned ADDR_W      = 8;
  localparam int unsigned DATA_W      = 8;
  localparam logic [7:0]  RESET_PC    = 8'h00;
  localparam logic [7:0]  HALT_OPCODE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_out_reg.sv
// One-entry valid/ready output slot for the fetch stage: load, hold, flush or drain on handshake.
module fetch_out_reg #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              ready_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W-1:0] pc_q;

  // Flush wins over load; a handshake with nothing new to load empties the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the ROM address and presents fetched bytes to decode.
module instruction_fetch #(
  parameter int unsigned ADDR_W      = cpu_pkg::ADDR_W,
  parameter int unsigned DATA_W      = cpu_pkg::DATA_W,
  parameter logic [7:0]  RESET_PC    = cpu_pkg::RESET_PC,
  parameter logic [7:0]  HALT_OPCODE = cpu_pkg::HALT_OPCODE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  import cpu_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q;
  logic              load_c;
  logic              flush_c;

  // Next-state and PC logic; redirect outranks everything except reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load_c  = 1'b0;
    flush_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) pc_d = redirect_addr;
        if (start) state_d = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d    = redirect_addr;
          flush_c = 1'b1;
        end else if (!instr_valid || instr_ready) begin
          load_c = 1'b1;
          if (imem_data == DATA_W'(HALT_OPCODE)) state_d = HALTED;
          else                                   pc_d    = pc_q + ADDR_W'(1);
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          pc_d    = redirect_addr;
          flush_c = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= ADDR_W'(RESET_PC);
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= (state_d == HALTED);
    end
  end

  fetch_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_out (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (load_c),
    .flush_i (flush_c),
    .ready_i (instr_ready),
    .data_i  (imem_data),
    .pc_i    (pc_q),
    .valid_o (instr_valid),
    .data_o  (instr),
    .pc_o    (instr_pc)
  );

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = halted_q;

endmodule
